// File: rtl/rcpwm_capture.sv
// RC/servo PWM capture: measures pulse high time in clk cycles, converts it to a
// signed position around the neutral width, and tracks validity with a timeout.
module rcpwm_capture #(
    parameter int unsigned servo_center = 72000,
    parameter int unsigned scale_shift  = 6,
    parameter int unsigned min_width    = 24000,
    parameter int unsigned max_width    = 120000,
    parameter int unsigned timeout      = 1440000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [31:0] value,
    output logic [31:0] width,
    output logic        valid,
    output logic        new_sample,
    output logic        pulse_err
);

    localparam logic [31:0] SC   = 32'(servo_center);
    localparam logic [31:0] MINW = 32'(min_width);
    localparam logic [31:0] MAXW = 32'(max_width);
    localparam logic [31:0] TO   = 32'(timeout);

    typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, HIGH} state_t;

    state_t      state_q;
    logic        s1_q, s2_q, s3_q;
    logic        rise_q, fall_q;
    logic [2:0]  prime_q;
    logic [31:0] cnt_q, tcnt_q;
    logic [31:0] value_q, width_q;
    logic        valid_q, new_sample_q, pulse_err_q;

    logic               in_range, accept, reject, overrun;
    logic signed [31:0] diff_s, scaled;

    always_comb begin
        in_range = (cnt_q >= MINW) && (cnt_q <= MAXW);
        overrun  = (state_q == HIGH) && !fall_q && s3_q && (cnt_q == MAXW);
        accept   = (state_q == HIGH) && fall_q && in_range;
        reject   = ((state_q == HIGH) && fall_q && !in_range) || overrun;
        diff_s   = $signed(cnt_q - SC);
        scaled   = diff_s >>> scale_shift;
    end

    // Edge flags are registered so the FSM sees one detect stage after the
    // synchroniser; s3 is the matching level. prime_q keeps WAIT_LOW from
    // trusting the cleared synchroniser before real pin samples reach it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_LOW;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            prime_q      <= '0;
            cnt_q        <= '0;
            tcnt_q       <= '0;
            value_q      <= '0;
            width_q      <= '0;
            valid_q      <= 1'b0;
            new_sample_q <= 1'b0;
            pulse_err_q  <= 1'b0;
        end else begin
            s1_q         <= pwm_in;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            rise_q       <= s2_q & ~s3_q;
            fall_q       <= ~s2_q & s3_q;
            prime_q      <= {prime_q[1:0], 1'b1};
            new_sample_q <= accept;
            pulse_err_q  <= reject;

            case (state_q)
                WAIT_LOW: begin
                    if (prime_q[2] && !s3_q) state_q <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise_q) begin
                        cnt_q   <= 32'd1;
                        state_q <= HIGH;
                    end
                end
                HIGH: begin
                    if (fall_q)        state_q <= WAIT_RISE;
                    else if (overrun)  state_q <= WAIT_LOW;
                    else               cnt_q   <= cnt_q + 32'd1;
                end
                default: state_q <= WAIT_LOW;
            endcase

            // An accepted pulse takes precedence over an expiring timeout.
            if (accept) begin
                width_q <= cnt_q;
                value_q <= scaled;
                valid_q <= 1'b1;
                tcnt_q  <= '0;
            end else if (tcnt_q != TO) begin
                tcnt_q <= tcnt_q + 32'd1;
                if (tcnt_q + 32'd1 == TO) begin
                    valid_q <= 1'b0;
                    value_q <= '0;
                end
            end
        end
    end

    assign value      = value_q;
    assign width      = width_q;
    assign valid      = valid_q;
    assign new_sample = new_sample_q;
    assign pulse_err  = pulse_err_q;

endmodule

// File: tb/tb_rcpwm_capture.sv
// Bench for rcpwm_capture at scaled-down widths: each driven pulse is classified
// from its length and turned into an expected strobe at a known cycle.
module tb_rcpwm_capture;

    localparam int C   = 360;
    localparam int SH  = 3;
    localparam int MIN = 120;
    localparam int MAX = 600;
    localparam int TO  = 3000;
    localparam int DIV = 1 << SH;
    localparam int LAT = 3;   // edges from the pin sample that decides a pulse to its strobe

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_in = 1'b0;
    logic [31:0] value, width;
    logic        valid, new_sample, pulse_err;

    rcpwm_capture #(
        .servo_center(C), .scale_shift(SH), .min_width(MIN),
        .max_width(MAX), .timeout(TO)
    ) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in),
        .value(value), .width(width), .valid(valid),
        .new_sample(new_sample), .pulse_err(pulse_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit acc;
        int w;
        int v;
    } ev_t;

    ev_t  expq[$];
    int   cyc = 0;
    bit   rst_edge = 1'b0;
    int   n_chk = 0, n_pass = 0;
    int   n_acc_exp = 0, n_err_exp = 0, n_acc_seen = 0, n_err_seen = 0;

    int   mw = 0, mv = 0, last_acc = 0;
    bit   has_acc = 1'b0, e_ns, e_err, e_valid;
    ev_t  ev;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, want %0d", tag, cyc, obs, exp);
    endtask

    // Floor division, which is what an arithmetic right shift computes.
    function automatic int expv(input int w);
        int d;
        d = w - C;
        return (d >= 0) ? d / DIV : -((-d + DIV - 1) / DIV);
    endfunction

    always @(posedge clk) begin
        cyc++;
        rst_edge = rst;
    end

    always @(negedge clk) begin
        e_ns  = 1'b0;
        e_err = 1'b0;
        if (rst_edge) begin
            has_acc = 1'b0;
            mw = 0;
            mv = 0;
        end else begin
            while (expq.size() > 0 && expq[0].cyc <= cyc) begin
                ev = expq.pop_front();
                if (ev.acc) begin
                    e_ns = 1'b1; mw = ev.w; mv = ev.v; last_acc = cyc; has_acc = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
            end
        end
        e_valid = has_acc && (cyc - last_acc < TO);
        if (new_sample) n_acc_seen++;
        if (pulse_err)  n_err_seen++;
        chk("new_sample", new_sample, e_ns);
        chk("pulse_err", pulse_err, e_err);
        chk("valid", valid, e_valid);
        chk("value", longint'($signed(value)), e_valid ? mv : 0);
        chk("width", width, mw);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // High for w cycles, then low for gap cycles; the expected outcome is queued first.
    task automatic pulse(input int w, input int gap);
        ev_t e;
        int  r;
        @(negedge clk);
        r = cyc + 1;
        e.w = w; e.v = 0; e.acc = 1'b0;
        if (w > MAX)      e.cyc = r + MAX + LAT;
        else if (w < MIN) e.cyc = r + w + LAT;
        else begin
            e.cyc = r + w + LAT; e.acc = 1'b1; e.v = expv(w);
        end
        if (e.acc) n_acc_exp++; else n_err_exp++;
        expq.push_back(e);
        pwm_in = 1'b1;
        idle(w);
        pwm_in = 1'b0;
        idle(gap);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog at cycle %0d: got timeout, want completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        rst = 1'b0;
        idle(20);

        repeat (3) pulse(C, 400);
        pulse(C + 8, 50);
        pulse(C - 8, 50);
        pulse(MAX, 50);
        pulse(MIN, 50);
        pulse(MIN - 1, 50);
        pulse(MAX + 50, 50);
        pulse(C, 1);
        pulse(C + 1, 1);
        pulse(C - 9, 1);

        idle(TO + 100);
        pulse(C + 120, 50);

        // Reset in the middle of a high pulse; that pulse must leave no trace.
        @(negedge clk);
        pwm_in = 1'b1;
        idle(100);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(200);
        pwm_in = 1'b0;
        idle(30);
        pulse(C, 40);

        pulse(1, 5);
        pulse(C - 40, 40);

        for (int i = 0; i < 20; i++)
            pulse(int'($urandom_range(MIN - 30, MAX + 30)), int'($urandom_range(1, 60)));

        idle(MAX + 20);
        chk("queue_drained", expq.size(), 0);
        chk("accept_count", n_acc_seen, n_acc_exp);
        chk("error_count", n_err_seen, n_err_exp);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
